// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS control FSM: per-state strobes for the shared ALU, memory, IR and GPR.
// Build option MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready under a WAIT_TIMEOUT watchdog.
module mccpu_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_IEXEC  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             mem_rdy;
  logic             mem_st;
  logic             r_ok;
  logic [2:0]       r_alu;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign state = state_q;

  // R-type function decode; r_ok flags a Funct this ISA implements
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_NOP;
    case (Funct)
      F_ADD, F_ADDU: r_alu = ALU_ADD;
      F_SUB, F_SUBU: r_alu = ALU_SUB;
      F_AND:         r_alu = ALU_AND;
      F_OR:          r_alu = ALU_OR;
      F_SLT:         r_alu = ALU_SLT;
      F_SLTU:        r_alu = ALU_SLTU;
      default:       r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = S_FETCH;
    cnt_n    = '0;
    mem_st   = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = ALU_NOP;
    NPCOp    = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_st  = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        PCWrite = mem_rdy;
        IRWrite = mem_rdy;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        EXTOp   = 1'b1;
        case (Op)
          OP_LW, OP_SW:    state_n = S_MEMADR;
          OP_RTYPE:        state_n = r_ok ? S_REXEC : S_FETCH;
          OP_ADDI, OP_ORI: state_n = S_IEXEC;
          OP_BEQ:          state_n = S_BRANCH;
          OP_J, OP_JAL:    state_n = S_JUMP;
          default:         state_n = S_FETCH;
        endcase
        illegal = (state_n == S_FETCH);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        EXTOp   = 1'b1;
        state_n = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_st  = 1'b1;
        IorD    = 1'b1;
        state_n = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        GPRSel   = 2'b01;
        WDSel    = 2'b01;
      end
      S_MEMWR: begin
        mem_st   = 1'b1;
        IorD     = 1'b1;
        MemWrite = mem_rdy;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = r_alu;
        state_n = S_ALUWB;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Op == OP_ORI) begin
          ALUOp = ALU_OR;
        end else begin
          ALUOp = ALU_ADD;
          EXTOp = 1'b1;
        end
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        GPRSel   = (Op == OP_RTYPE) ? 2'b00 : 2'b01;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        NPCOp   = 2'b01;
        PCWrite = Zero;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        NPCOp   = 2'b10;
        if (Op == OP_JAL) begin
          RegWrite = 1'b1;
          GPRSel   = 2'b10;
          WDSel    = 2'b10;
        end
      end
      default: state_n = S_FETCH;
    endcase

    // A memory state holds until ready; the watchdog abandons the access and refetches
    if (mem_st && !mem_rdy) begin
      if (cnt_q == CNT_LAST) begin
        mem_err = 1'b1;
        state_n = S_FETCH;
      end else begin
        cnt_n   = cnt_q + CNT_W'(1);
        state_n = state_q;
      end
    end

    // Strobes are quiet while reset is held so an aborted instruction leaves no write
    if (!rstn) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = ALU_NOP;
      NPCOp    = 2'b00;
      GPRSel   = 2'b00;
      WDSel    = 2'b00;
      illegal  = 1'b0;
      mem_err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Directed scoreboard bench for mccpu_ctrl: the full state/strobe vector is predicted per cycle.
module tb_mccpu_ctrl;
  typedef struct {
    logic [23:0] v;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, IorD, RegWrite, MemWrite, EXTOp, ALUSrcA;
  logic [1:0] ALUSrcB, NPCOp, GPRSel, WDSel;
  logic [2:0] ALUOp;
  logic       illegal, mem_err;
  logic [3:0] state;
  logic [23:0] obs;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  assign obs = {state, PCWrite, IRWrite, IorD, RegWrite, MemWrite, EXTOp, ALUSrcA,
                ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, illegal, mem_err};

  always #5 clk = ~clk;

  mccpu_ctrl #(.WAIT_TIMEOUT(3)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .Op       (Op),
    .Funct    (Funct),
    .Zero     (Zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite  (PCWrite),
    .IRWrite  (IRWrite),
    .IorD     (IorD),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .EXTOp    (EXTOp),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .NPCOp    (NPCOp),
    .GPRSel   (GPRSel),
    .WDSel    (WDSel),
    .illegal  (illegal),
    .mem_err  (mem_err),
    .state    (state)
  );

  function automatic logic legal(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      6'h00: return funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};
      6'h02, 6'h03, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] funct);
    case (funct)
      6'h20, 6'h21: return 3'b001;
      6'h22, 6'h23: return 3'b010;
      6'h24:        return 3'b011;
      6'h25:        return 3'b100;
      6'h2A:        return 3'b101;
      6'h2B:        return 3'b110;
      default:      return 3'b000;
    endcase
  endfunction

  // Expected control vector for a state, straight from the per-state strobe table
  function automatic logic [23:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                          input logic [5:0] funct, input logic zero,
                                          input logic rdy, input logic merr);
    logic pcw, irw, iord, rw, mw, ext, srca, ill;
    logic [1:0] srcb, npc, gsel, wsel;
    logic [2:0] aop;
    {pcw, irw, iord, rw, mw, ext, srca, ill} = '0;
    {srcb, npc, gsel, wsel} = '0;
    aop = 3'b000;
    case (st)
      4'd0:  begin pcw = rdy; irw = rdy; srcb = 2'b01; aop = 3'b001; end
      4'd1:  begin srcb = 2'b11; aop = 3'b001; ext = 1'b1; ill = !legal(op, funct); end
      4'd2:  begin srca = 1'b1; srcb = 2'b10; aop = 3'b001; ext = 1'b1; end
      4'd3:  iord = 1'b1;
      4'd4:  begin rw = 1'b1; gsel = 2'b01; wsel = 2'b01; end
      4'd5:  begin iord = 1'b1; mw = rdy; end
      4'd6:  begin srca = 1'b1; aop = r_alu(funct); end
      4'd7:  begin
        srca = 1'b1; srcb = 2'b10;
        if (op == 6'h08) begin aop = 3'b001; ext = 1'b1; end
        else aop = 3'b100;
      end
      4'd8:  begin rw = 1'b1; gsel = (op == 6'h00) ? 2'b00 : 2'b01; end
      4'd9:  begin srca = 1'b1; aop = 3'b010; npc = 2'b01; pcw = zero; end
      4'd10: begin
        pcw = 1'b1; npc = 2'b10;
        if (op == 6'h03) begin rw = 1'b1; gsel = 2'b10; wsel = 2'b10; end
      end
      default: ;
    endcase
    return {st, pcw, irw, iord, rw, mw, ext, srca, srcb, aop, npc, gsel, wsel, ill, merr};
  endfunction

  task automatic push_raw(input string tag, input logic [23:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push(input string tag, input logic [3:0] st, input logic rdy, input logic merr);
    push_raw(tag, exp_vec(st, Op, Funct, Zero, rdy, merr));
  endtask

  task automatic compare_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (state %0d)", e.tag, obs, e.v, e.v[23:20]);
    end
  endtask

  task automatic sample_neg();
    @(negedge clk);
    compare_pop();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample_neg();
    advance();
  endtask

  // Drive one instruction and predict its state walk (s0 in the top nibble of seq)
  task automatic issue(input string tag, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input int n, input logic [19:0] seq);
    Op    = op;
    Funct = funct;
    Zero  = zero;
    for (int i = 0; i < n; i++) push(tag, seq[19-4*i -: 4], 1'b1, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    Op        = 6'h23;
    Funct     = 6'h00;
    Zero      = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    push_raw("reset", 24'h0);
    sample_neg();
    advance();
    rstn = 1'b1;

    issue("add",   6'h00, 6'h20, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("sub",   6'h00, 6'h22, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("and",   6'h00, 6'h24, 1'b1, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("or",    6'h00, 6'h25, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("slt",   6'h00, 6'h2A, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("sltu",  6'h00, 6'h2B, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("subu",  6'h00, 6'h23, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});
    issue("addi",  6'h08, 6'h11, 1'b0, 4, {4'd0, 4'd1, 4'd7, 4'd8, 4'd0});
    issue("ori",   6'h0D, 6'h00, 1'b0, 4, {4'd0, 4'd1, 4'd7, 4'd8, 4'd0});
    issue("lw",    6'h23, 6'h00, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
    issue("sw",    6'h2B, 6'h00, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0});
    issue("beq_t", 6'h04, 6'h00, 1'b1, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0});
    issue("beq_n", 6'h04, 6'h00, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0});
    issue("j",     6'h02, 6'h00, 1'b0, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0});
    issue("jal",   6'h03, 6'h00, 1'b0, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0});
    issue("ill_op", 6'h3F, 6'h20, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0});
    issue("ill_fn", 6'h00, 6'h00, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0});
    issue("after_ill", 6'h00, 6'h21, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});

    // lw aborted by reset while in MEMWB: strobes drop before the write edge
    issue("lw_abort", 6'h23, 6'h00, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd3, 4'd0});
    push("lw_memwb", 4'd4, 1'b1, 1'b0);
    sample_neg();
    #1 rstn = 1'b0;
    #1 push_raw("abort_now", 24'h0);
    compare_pop();
    advance();
    push_raw("abort_hold", 24'h0);
    compare_pop();
    rstn = 1'b1;
    issue("post_abort", 6'h00, 6'h20, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd8, 4'd0});

`ifdef MEM_WAIT_EN
    // MEMWR never ready: three stalled cycles, watchdog pulse on the third, no write
    Op = 6'h2B; Funct = 6'h00; Zero = 1'b0;
    push("sw_tmo", 4'd0, 1'b1, 1'b0);
    push("sw_tmo", 4'd1, 1'b1, 1'b0);
    push("sw_tmo", 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b0;
    push("sw_tmo_w0", 4'd5, 1'b0, 1'b0);
    push("sw_tmo_w1", 4'd5, 1'b0, 1'b0);
    push("sw_tmo_err", 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b1;
    // MEMWR ready on its second cycle: exactly one MemWrite cycle
    push("sw_late", 4'd0, 1'b1, 1'b0);
    push("sw_late", 4'd1, 1'b1, 1'b0);
    push("sw_late", 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b0;
    push("sw_late_w0", 4'd5, 1'b0, 1'b0);
    step();
    mem_ready = 1'b1;
    push("sw_late_wr", 4'd5, 1'b1, 1'b0);
    step();
    issue("post_wait", 6'h0D, 6'h00, 1'b0, 4, {4'd0, 4'd1, 4'd7, 4'd8, 4'd0});
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
